xc_aesmix_seq: RTL and testbench

Sequencer that runs a full 128-bit AES MixColumns or InvMixColumns over one shared `xc_aesmix` column datapath. It latches a 4-column state, issues one column operation at a time over the datapath's valid/ready handshake, and drives the datapath flush on every completion. It assembles the four results and reports completion with a one-cycle `done` pulse. It sits between the crypto-instruction issue logic and either the FAST or the area-optimised `xc_aesmix` instance, and works unchanged with both.

---
 rtl/xc_aesmix_seq.sv | 177 +++++++++++++++++
 tb/tb_xc_aesmix_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_aesmix_seq.sv
`default_nettype none
// ============================================================================
// Module   : xc_aesmix_seq
// Purpose  : Sequences a full 128-bit AES MixColumns / InvMixColumns over a
//            single shared xc_aesmix column datapath. It latches a 4-column
//            state and issues one column at a time over the datapath
//            valid/ready handshake. It flushes the datapath on every
//            completion, assembles the four results and pulses done.
//            Works with both the same-cycle (FAST) and the multi-cycle
//            (area-optimised) xc_aesmix variants.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock           in   1    system clock, rising edge
//   reset           in   1    synchronous, active-low reset
//   start           in   1    begin an operation (sampled in IDLE only)
//   enc             in   1    1 = MixColumns, 0 = InvMixColumns
//   state_in        in   128  column c = state_in[32c+31:32c]
//   abort           in   1    cancel the running operation
//   rand_data       in   32   randomness forwarded to mix_flush_data
//   busy            out  1    operation in progress (through DONE cycle)
//   done            out  1    one-cycle completion pulse
//   state_out       out  128  result state, held until next accepted start
//   mix_valid       out  1    datapath request valid
//   mix_rs1         out  32   {16'h0, col[15:0]}
//   mix_rs2         out  32   {col[31:16], 16'h0}
//   mix_enc         out  1    latched enc
//   mix_flush       out  1    datapath flush (combinational)
//   mix_flush_data  out  32   equals rand_data
//   mix_ready       in   1    datapath result ready
//   mix_result      in   32   datapath column result
// ============================================================================
module xc_aesmix_seq (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         enc,
  input  logic [127:0] state_in,
  input  logic         abort,
  input  logic [31:0]  rand_data,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out,
  output logic         mix_valid,
  output logic [31:0]  mix_rs1,
  output logic [31:0]  mix_rs2,
  output logic         mix_enc,
  output logic         mix_flush,
  output logic [31:0]  mix_flush_data,
  input  logic         mix_ready,
  input  logic [31:0]  mix_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        fsm_q;
  logic [1:0]    col_q;
  logic [127:0]  src_q;      // state latched at start; state_in may change later
  logic [127:0]  out_q;
  logic          busy_q;
  logic          done_q;
  logic          valid_q;
  logic          enc_q;
  logic [31:0]   rs1_q;
  logic [31:0]   rs2_q;

  logic          hs_fire;    // request accepted by the datapath this cycle
  logic [1:0]    col_d;
  logic [31:0]   nxt_word;   // next column to present after a handshake

  // Select one 32-bit column out of a 128-bit state.
  function automatic logic [31:0] column_of(input logic [127:0] s,
                                            input logic [1:0]   c);
    logic [31:0] w;
    case (c)
      2'd0:    w = s[31:0];
      2'd1:    w = s[63:32];
      2'd2:    w = s[95:64];
      default: w = s[127:96];
    endcase
    return w;
  endfunction

  assign hs_fire  = valid_q & mix_ready;
  assign col_d    = col_q + 2'd1;
  assign nxt_word = column_of(src_q, col_d);

  always_ff @(posedge clock) begin
    if (!reset) begin
      fsm_q   <= IDLE;
      col_q   <= 2'd0;
      src_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      enc_q   <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          // abort blocks a same-cycle start
          if (start && !abort) begin
            src_q   <= state_in;
            enc_q   <= enc;
            col_q   <= 2'd0;
            out_q   <= '0;
            rs1_q   <= {16'h0000, state_in[15:0]};
            rs2_q   <= {state_in[31:16], 16'h0000};
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            fsm_q   <= ISSUE;
          end
        end

        ISSUE: begin
          if (abort) begin
            // abort wins over a coincident ready: the result is dropped
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            col_q   <= 2'd0;
            fsm_q   <= IDLE;
          end else if (hs_fire) begin
            case (col_q)
              2'd0:    out_q[31:0]   <= mix_result;
              2'd1:    out_q[63:32]  <= mix_result;
              2'd2:    out_q[95:64]  <= mix_result;
              default: out_q[127:96] <= mix_result;
            endcase
            if (col_q == 2'd3) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              col_q   <= 2'd0;
              fsm_q   <= DONE;
            end else begin
              // back-to-back issue: valid stays high, operands advance
              col_q <= col_d;
              rs1_q <= {16'h0000, nxt_word[15:0]};
              rs2_q <= {nxt_word[31:16], 16'h0000};
            end
          end
        end

        DONE: begin
          busy_q <= 1'b0;
          fsm_q  <= IDLE;
        end

        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          col_q   <= 2'd0;
          fsm_q   <= IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign state_out      = out_q;
  assign mix_valid      = valid_q;
  assign mix_rs1        = rs1_q;
  assign mix_rs2        = rs2_q;
  assign mix_enc        = enc_q;
  // Flush on every completed handshake and on an abort of a live request.
  assign mix_flush      = valid_q & (mix_ready | abort);
  assign mix_flush_data = rand_data;

endmodule
`default_nettype wire

// File: tb/tb_xc_aesmix_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_xc_aesmix_seq
// Purpose  : Self-checking bench for xc_aesmix_seq. A responder stands in for
//            the xc_aesmix column datapath (same-cycle or multi-cycle ready),
//            a scoreboard queue holds the expected state for each accepted
//            operation and a monitor compares it on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xc_aesmix_seq;

  logic         clock      = 1'b0;
  logic         reset      = 1'b0;
  logic         start      = 1'b0;
  logic         enc        = 1'b0;
  logic [127:0] state_in   = '0;
  logic         abort      = 1'b0;
  logic [31:0]  rand_data  = '0;
  logic         mix_ready  = 1'b0;
  logic [31:0]  mix_result = '0;
  logic         busy;
  logic         done;
  logic [127:0] state_out;
  logic         mix_valid;
  logic [31:0]  mix_rs1;
  logic [31:0]  mix_rs2;
  logic         mix_enc;
  logic         mix_flush;
  logic [31:0]  mix_flush_data;

  xc_aesmix_seq dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .enc            (enc),
    .state_in       (state_in),
    .abort          (abort),
    .rand_data      (rand_data),
    .busy           (busy),
    .done           (done),
    .state_out      (state_out),
    .mix_valid      (mix_valid),
    .mix_rs1        (mix_rs1),
    .mix_rs2        (mix_rs2),
    .mix_enc        (mix_enc),
    .mix_flush      (mix_flush),
    .mix_flush_data (mix_flush_data),
    .mix_ready      (mix_ready),
    .mix_result     (mix_result)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: AES column mixing over GF(2^8) -------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix: row r, byte k uses coef[(k - r) mod 4]
  function automatic logic [31:0] mixcol(input logic [31:0] w, input logic e);
    logic [7:0]  coef [4];
    logic [31:0] r;
    logic [7:0]  acc;
    if (e) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    else   coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    r = '0;
    for (int row = 0; row < 4; row++) begin
      acc = 8'h00;
      for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row + 4) % 4], w[8*k +: 8]);
      r[8*row +: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_state(input logic [127:0] s, input logic e);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = mixcol(s[32*c +: 32], e);
    return r;
  endfunction

  // ---------------- datapath responder ------------------------------------
  int          lat_mode = 0;    // 0: ready same cycle, 1: 1..3 wait cycles
  int          allow    = -1;   // handshakes still permitted (-1 = unlimited)
  int          wait_cnt = 0;
  int          lat      = 0;
  int          hs_idx   = 0;    // column index of the request being served
  logic [31:0] hold_rs1 = '0;
  logic [31:0] hold_rs2 = '0;
  logic [31:0] cap_rs1 [4];
  logic [31:0] cap_rs2 [4];

  always @(negedge clock) begin
    if (!mix_valid) begin
      mix_ready = 1'b0;
      wait_cnt  = 0;
    end else begin
      if (wait_cnt == 0) begin
        hold_rs1 = mix_rs1;
        hold_rs2 = mix_rs2;
        if (hs_idx < 4) begin
          cap_rs1[hs_idx] = mix_rs1;
          cap_rs2[hs_idx] = mix_rs2;
        end
        lat = (lat_mode != 0) ? int'($urandom_range(3, 1)) : 0;
      end else begin
        check("rs1 stable while waiting", 256'(mix_rs1), 256'(hold_rs1));
        check("rs2 stable while waiting", 256'(mix_rs2), 256'(hold_rs2));
      end
      if (wait_cnt >= lat && allow != 0) begin
        mix_ready  = 1'b1;
        mix_result = mixcol({mix_rs2[31:16], mix_rs1[15:0]}, mix_enc);
        wait_cnt   = 0;
        hs_idx++;
        if (allow > 0) allow--;
      end else begin
        mix_ready = 1'b0;
        wait_cnt++;
      end
    end
  end

  // ---------------- scoreboard monitor ------------------------------------
  logic [127:0] exp_q [$];
  int           done_cnt      = 0;
  int           flush_cnt     = 0;
  int           last_done_cyc = 0;
  logic         prev_done     = 1'b0;

  always @(negedge clock) begin
    #1;
    if (mix_flush) flush_cnt++;
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
      check("done single-cycle", 256'(prev_done), 256'(1'b0));
      check("busy during done", 256'(busy), 256'(1'b1));
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard: done with no pending operation, state_out=%h", state_out);
      end else begin
        check("scoreboard state_out", 256'(state_out), 256'(exp_q.pop_front()));
      end
    end
    prev_done = done;
  end

  // ---------------- one complete operation --------------------------------
  task automatic run_op(input logic [127:0] s, input logic e, input int mode,
                        output logic [127:0] res, output int dcyc);
    int           d0;
    int           f0;
    int           t1;
    logic [127:0] expv;
    expv     = mix_state(s, e);
    lat_mode = mode;
    allow    = -1;
    d0       = done_cnt;
    @(negedge clock);
    state_in  = s;
    enc       = e;
    start     = 1'b1;
    rand_data = $urandom;
    hs_idx    = 0;
    exp_q.push_back(expv);
    @(negedge clock);
    start    = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    enc      = ~e;
    f0       = flush_cnt;
    #2;
    t1 = cyc;
    check("busy after start", 256'(busy), 256'(1'b1));
    check("mix_valid after start", 256'(mix_valid), 256'(1'b1));
    check("mix_enc latched", 256'(mix_enc), 256'(e));
    check("state_out cleared at start", 256'(state_out), 256'(0));
    check("mix_flush_data", 256'(mix_flush_data), 256'(rand_data));
    for (int i = 0; i < 80; i++) begin
      if (done_cnt != d0) break;
      @(negedge clock);
      start    = (i == 0);   // start while busy must be ignored
      state_in = {$urandom, $urandom, $urandom, $urandom};
      #2;
    end
    start = 1'b0;
    check("one done per operation", 256'(done_cnt - d0), 256'(1));
    check("flush pulses per operation", 256'(flush_cnt - f0), 256'(4));
    dcyc = last_done_cyc - t1;
    res  = state_out;
    @(negedge clock);
    #2;
    check("busy low after done", 256'(busy), 256'(1'b0));
    check("state_out held", 256'(state_out), 256'(expv));
  endtask

  localparam logic [127:0] S_PLAIN = {32'h4c31262d, 32'h01010101, 32'h5c220af2, 32'h455313db};
  localparam logic [127:0] S_MIXED = {32'hf8bd7e4d, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [127:0] s;
    logic [127:0] res;
    logic [127:0] expv;
    int           dcyc;
    int           d0;
    int           f0;

    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    check("reset outputs", 256'({busy, done, mix_valid, mix_enc, mix_flush, mix_rs1, mix_rs2, state_out}), 256'(0));
    @(negedge clock);
    reset = 1'b1;

    // MixColumns, same-cycle datapath
    run_op(S_PLAIN, 1'b1, 0, res, dcyc);
    check("enc known vector", 256'(res), 256'(S_MIXED));
    check("done in cycle 5", 256'(dcyc), 256'(4));

    // InvMixColumns, multi-cycle datapath
    run_op(S_MIXED, 1'b0, 1, res, dcyc);
    check("dec known vector", 256'(res), 256'(S_PLAIN));

    // single-column vectors in column 2
    s = {$urandom, 32'hd5d4d4d4, $urandom, $urandom};
    run_op(s, 1'b1, 0, res, dcyc);
    check("col2 d5d4d4d4", 256'(res[95:64]), 256'(32'hd6d7d5d5));
    check("col2 rs1 encoding", 256'(cap_rs1[2]), 256'(32'h0000d4d4));
    check("col2 rs2 encoding", 256'(cap_rs2[2]), 256'(32'hd5d40000));
    s = {$urandom, 32'hc6c6c6c6, $urandom, $urandom};
    run_op(s, 1'b1, 1, res, dcyc);
    check("col2 c6c6c6c6", 256'(res[95:64]), 256'(32'hc6c6c6c6));

    // abort while column 2 waits for ready
    s        = {$urandom, $urandom, $urandom, $urandom};
    expv     = mix_state(s, 1'b1);
    lat_mode = 0;
    allow    = 2;
    d0       = done_cnt;
    @(negedge clock);
    state_in = s; enc = 1'b1; start = 1'b1; hs_idx = 0;
    @(negedge clock);
    start = 1'b0;
    #2;
    for (int i = 0; i < 20; i++) begin
      if (hs_idx >= 2) break;
      @(negedge clock);
      #2;
    end
    @(negedge clock);
    abort = 1'b1;
    f0    = flush_cnt;
    #2;
    check("abort flush", 256'(mix_flush), 256'(1'b1));
    check("abort on col2 rs1", 256'(mix_rs1), 256'({16'h0000, s[79:64]}));
    check("abort one flush counted", 256'(flush_cnt - f0), 256'(1));
    @(negedge clock);
    abort = 1'b0;
    allow = -1;
    #2;
    check("idle after abort", 256'({busy, mix_valid, done}), 256'(0));
    check("partial state_out after abort", 256'(state_out), 256'({64'h0, expv[63:0]}));
    repeat (4) @(negedge clock);
    #2;
    check("no done after abort", 256'(done_cnt - d0), 256'(0));

    // abort coinciding with ready: the result must be dropped
    s    = {$urandom, $urandom, $urandom, $urandom};
    expv = mix_state(s, 1'b0);
    @(negedge clock);
    state_in = s; enc = 1'b0; start = 1'b1; hs_idx = 0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    abort = 1'b1;
    #2;
    check("abort+ready flush", 256'({mix_ready, mix_flush}), 256'(2'b11));
    @(negedge clock);
    abort = 1'b0;
    #2;
    check("abort+ready result dropped", 256'({busy, state_out}), 256'({1'b0, 96'h0, expv[31:0]}));

    // start together with abort in IDLE
    @(negedge clock);
    start = 1'b1; abort = 1'b1; state_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    #2;
    check("start+abort ignored", 256'({busy, mix_valid}), 256'(0));
    @(negedge clock);
    #2;
    check("busy stays low", 256'(busy), 256'(1'b0));

    // reset in the middle of an operation
    d0       = done_cnt;
    lat_mode = 1;
    @(negedge clock);
    state_in = {$urandom, $urandom, $urandom, $urandom}; enc = 1'b1; start = 1'b1; hs_idx = 0;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #2;
    check("mid-op reset outputs", 256'({busy, done, mix_valid, mix_enc, mix_flush, mix_rs1, mix_rs2, state_out}), 256'(0));
    @(negedge clock);
    reset = 1'b1;
    check("no done after reset", 256'(done_cnt - d0), 256'(0));
    run_op(S_PLAIN, 1'b1, 0, res, dcyc);
    check("run after reset", 256'(res), 256'(S_MIXED));

    // randomized operations
    for (int n = 0; n < 12; n++) begin
      int m;
      m = int'($urandom_range(1, 0));
      s = {$urandom, $urandom, $urandom, $urandom};
      run_op(s, 1'($urandom_range(1, 0)), m, res, dcyc);
      if (m == 0) check("fast latency", 256'(dcyc), 256'(4));
    end

    repeat (3) @(negedge clock);
    #2;
    check("scoreboard drained", 256'(exp_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
